// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues in-order requests to a variable-latency
// instruction memory, buffers returned words and drops wrong-path responses after redirects.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] instruction,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic        FetchValid
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DepthW = (CW + 1)'(DEPTH);

    logic [31:0]   pc_req_q, pc_req_d;
    logic [31:0]   pc_rsp_q, pc_rsp_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   buf_pc_q   [DEPTH];
    logic [31:0]   buf_word_q [DEPTH];

    logic          empty, rsp_ok, req_fire, push, pop;
    logic [CW:0]   credit_used;
    logic          unused_tgt_bits;

    assign unused_tgt_bits = ^PCTargetE[1:0];

    assign empty       = (count_q == '0);
    // A response with nothing outstanding is a protocol violation and is ignored.
    assign rsp_ok      = imem_rsp_valid && (outstanding_q != '0);
    assign credit_used = {1'b0, outstanding_q} + {1'b0, count_q};

    assign imem_req_valid = !rst && !PCSrcE && (credit_used < DepthW);
    assign imem_req_addr  = pc_req_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    always_comb begin
        pc_req_d      = pc_req_q;
        pc_rsp_d      = pc_rsp_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        push          = 1'b0;
        pop           = 1'b0;

        if (PCSrcE) begin
            // Everything still in flight after this cycle belongs to the wrong path.
            pc_req_d      = {PCTargetE[31:2], 2'b00};
            pc_rsp_d      = {PCTargetE[31:2], 2'b00};
            outstanding_d = outstanding_q - CW'(rsp_ok);
            discard_d     = outstanding_q - CW'(rsp_ok);
            count_d       = '0;
            rd_ptr_d      = '0;
            wr_ptr_d      = '0;
        end else begin
            if (req_fire) begin
                pc_req_d = pc_req_q + 32'd4;
            end
            outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_ok);
            if (rsp_ok) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - CW'(1);
                end else begin
                    push = 1'b1;
                end
            end
            pop = !StallF && !empty;
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                pc_rsp_d = pc_rsp_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_req_q      <= RESET_PC;
            pc_rsp_q      <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            pc_req_q      <= pc_req_d;
            pc_rsp_q      <= pc_rsp_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc_q[wr_ptr_q]   <= pc_rsp_q;
            buf_word_q[wr_ptr_q] <= imem_rsp_data;
        end
    end

    always_comb begin
        instruction = NOP;
        PCF         = pc_rsp_q;
        FetchValid  = 1'b0;
        if (!empty) begin
            instruction = buf_word_q[rd_ptr_q];
            PCF         = buf_pc_q[rd_ptr_q];
            FetchValid  = 1'b1;
        end
        PCPlus4F = PCF + 32'd4;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model plus a queue-based reference
// model compared every cycle, with directed scenarios and literal expectations.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk, rst, StallF, PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] instruction, PCF, PCPlus4F;
    logic        FetchValid;

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH),
        .NOP      (NOP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .StallF         (StallF),
        .PCSrcE         (PCSrcE),
        .PCTargetE      (PCTargetE),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instruction    (instruction),
        .PCF            (PCF),
        .PCPlus4F       (PCPlus4F),
        .FetchValid     (FetchValid)
    );

    int errors = 0;
    int checks = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory: in-order, answers one accepted request per cycle when enabled, data = addr|0x100.
    logic [31:0] mem_q [$];
    bit          rsp_en;
    logic        mem_fire, mem_took;
    logic [31:0] mem_addr;

    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            mem_fire = imem_req_valid && imem_req_ready;
            mem_addr = imem_req_addr;
            mem_took = imem_rsp_valid;
            @(posedge clk);
            #1;
            if (rst) begin
                mem_q.delete();
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = '0;
            end else begin
                if (mem_took && mem_q.size() != 0) void'(mem_q.pop_front());
                if (mem_fire) mem_q.push_back(mem_addr);
                imem_rsp_valid = rsp_en && (mem_q.size() != 0);
                imem_rsp_data  = imem_rsp_valid ? (mem_q[0] | 32'h100) : 32'h0;
            end
        end
    end

    // Reference model: each in-flight request carries a keep flag cleared by a redirect.
    typedef struct packed {logic [31:0] addr; logic keep;} infl_t;
    typedef struct packed {logic [31:0] pc; logic [31:0] word;} ent_t;
    infl_t       inflight [$];
    ent_t        fifo_m [$];
    infl_t       r;
    logic [31:0] m_pc_req = RESET_PC;
    logic        e_rv, e_fv, pop_ok, rsp_keep;
    logic [31:0] e_pc, e_ins, rsp_addr;

    always @(negedge clk) begin
        if (rst) begin
            inflight.delete();
            fifo_m.delete();
            m_pc_req = RESET_PC;
        end
        e_rv = !rst && !PCSrcE && ((inflight.size() + fifo_m.size()) < DEPTH);
        chk("req_valid", 32'(imem_req_valid), 32'(e_rv));
        if (e_rv) chk("req_addr", imem_req_addr, m_pc_req);
        if (fifo_m.size() != 0) begin
            e_fv  = 1'b1;
            e_pc  = fifo_m[0].pc;
            e_ins = fifo_m[0].word;
        end else begin
            e_fv  = 1'b0;
            e_ins = NOP;
            e_pc  = m_pc_req;
            for (int i = inflight.size() - 1; i >= 0; i--) begin
                if (inflight[i].keep) e_pc = inflight[i].addr;
            end
        end
        chk("FetchValid", 32'(FetchValid), 32'(e_fv));
        chk("PCF", PCF, e_pc);
        chk("instruction", instruction, e_ins);
        chk("PCPlus4F", PCPlus4F, e_pc + 32'd4);

        if (!rst) begin
            assert (!(imem_rsp_valid && inflight.size() == 0))
            else begin
                errors++;
                $display("FAIL protocol: response with nothing outstanding at %0t", $time);
            end
            pop_ok   = !StallF && !PCSrcE && (fifo_m.size() != 0);
            rsp_keep = 1'b0;
            rsp_addr = '0;
            if (imem_rsp_valid && inflight.size() != 0) begin
                r        = inflight.pop_front();
                rsp_keep = r.keep && !PCSrcE;
                rsp_addr = r.addr;
            end
            if (PCSrcE) begin
                fifo_m.delete();
                for (int i = 0; i < inflight.size(); i++) inflight[i].keep = 1'b0;
                m_pc_req = {PCTargetE[31:2], 2'b00};
            end else begin
                if (pop_ok) void'(fifo_m.pop_front());
                if (rsp_keep) fifo_m.push_back({rsp_addr, imem_rsp_data});
                if (e_rv && imem_req_ready) begin
                    inflight.push_back({m_pc_req, 1'b1});
                    m_pc_req = m_pc_req + 32'd4;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_fv();
        int n = 0;
        while (!FetchValid && n < 50) begin
            tick();
            n++;
        end
        if (!FetchValid) begin
            checks++;
            errors++;
            $display("FAIL wait_fv: FetchValid got 0 required 1 within 50 cycles at %0t", $time);
        end
    endtask

    initial begin
        rst            = 1'b1;
        StallF         = 1'b0;
        PCSrcE         = 1'b0;
        PCTargetE      = '0;
        imem_req_ready = 1'b1;
        rsp_en         = 1'b1;
        repeat (3) tick();
        chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
        chk("rst_instr", instruction, 32'h13);
        chk("rst_pcf", PCF, 32'h0);
        chk("rst_pcplus4", PCPlus4F, 32'h4);
        chk("rst_fv", 32'(FetchValid), 32'h0);

        // Streaming after reset release
        rst = 1'b0;
        chk("first_addr", imem_req_addr, 32'h0);
        tick();
        chk("fv_1cyc", 32'(FetchValid), 32'h0);
        chk("second_addr", imem_req_addr, 32'h4);
        tick();
        chk("fv_2cyc", 32'(FetchValid), 32'h1);
        chk("w0_pcf", PCF, 32'h0);
        chk("w0_instr", instruction, 32'h100);
        chk("w0_pcplus4", PCPlus4F, 32'h4);
        tick();
        chk("w1_pcf", PCF, 32'h4);
        chk("w1_instr", instruction, 32'h104);

        // Stall three cycles, buffer fills up
        StallF = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pcf", PCF, 32'h4);
            chk("stall_instr", instruction, 32'h104);
            chk("stall_req_valid", 32'(imem_req_valid), 32'h0);
        end
        StallF = 1'b0;
        tick();
        chk("resume_pcf", PCF, 32'h8);
        chk("resume_instr", instruction, 32'h108);

        // Two outstanding (12, 16), then redirect to 0x200
        rsp_en = 1'b0;
        tick();
        tick();
        chk("pre_redir_fv", 32'(FetchValid), 32'h0);
        chk("pre_redir_pcf", PCF, 32'hC);
        PCSrcE    = 1'b1;
        PCTargetE = 32'h200;
        chk("redir_req_valid", 32'(imem_req_valid), 32'h0);
        tick();
        PCSrcE = 1'b0;
        rsp_en = 1'b1;
        chk("redir_addr", imem_req_addr, 32'h200);
        chk("redir_pcf", PCF, 32'h200);
        wait_fv();
        chk("redir_w_pcf", PCF, 32'h200);
        chk("redir_w_instr", instruction, 32'h300);

        // Redirect coinciding with a response, unaligned target
        for (int i = 0; i < 20 && !imem_rsp_valid; i++) tick();
        chk("rsp_seen", 32'(imem_rsp_valid), 32'h1);
        PCSrcE    = 1'b1;
        PCTargetE = 32'h403;
        tick();
        PCSrcE = 1'b0;
        chk("align_addr", imem_req_addr, 32'h400);
        chk("align_fv", 32'(FetchValid), 32'h0);
        wait_fv();
        chk("align_pcf", PCF, 32'h400);
        chk("align_instr", instruction, 32'h500);

        // Memory not ready for 5 cycles
        imem_req_ready = 1'b0;
        PCSrcE         = 1'b1;
        PCTargetE      = 32'h1000;
        tick();
        PCSrcE = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 5; i++) begin
            chk("nr_req_valid", 32'(imem_req_valid), 32'h1);
            chk("nr_addr", imem_req_addr, 32'h1000);
            chk("nr_fv", 32'(FetchValid), 32'h0);
            chk("nr_instr", instruction, 32'h13);
            chk("nr_pcf", PCF, 32'h1000);
            tick();
        end
        imem_req_ready = 1'b1;
        wait_fv();
        chk("nr_w_pcf", PCF, 32'h1000);

        // Address wrap at 2^32
        PCSrcE    = 1'b1;
        PCTargetE = 32'hFFFF_FFFC;
        tick();
        PCSrcE = 1'b0;
        chk("wrap_addr", imem_req_addr, 32'hFFFF_FFFC);
        wait_fv();
        chk("wrap_pcf", PCF, 32'hFFFF_FFFC);
        chk("wrap_pcplus4", PCPlus4F, 32'h0);
        chk("wrap_instr", instruction, 32'hFFFF_FFFC);
        tick();
        wait_fv();
        chk("wrap_next_pcf", PCF, 32'h0);
        chk("wrap_next_instr", instruction, 32'h100);
        chk("wrap_next_pcplus4", PCPlus4F, 32'h4);

        // Reset in the middle of traffic
        repeat (2) tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_fv", 32'(FetchValid), 32'h0);
        chk("mid_rst_pcf", PCF, 32'h0);
        chk("mid_rst_req_valid", 32'(imem_req_valid), 32'h0);
        tick();
        rst = 1'b0;
        wait_fv();
        chk("post_rst_pcf", PCF, 32'h0);
        chk("post_rst_instr", instruction, 32'h100);

        repeat (4) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
